alu_pipelined: RTL and testbench

Parametrised successor to the 8-bit nRisc pipeline ALU. It executes the same 3-bit opcode set, widened to `WIDTH` bits, and adds AND, OR and SLT. Multiply is a sequential shift-add unit. Both sides use a valid/ready handshake, so the execute stage can stall on a busy multiplier and accept back-pressure from writeback. It also produces status flags and a qualified branch-target output.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_mul_seq.sv | 49 ++++
 rtl/alu_pipelined.sv | 138 +++++++++++++
 tb/tb_alu_pipelined.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcode encodings and execute-stage FSM states.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_BEQ = 3'b110;
  localparam logic [2:0] OP_BNZ = 3'b111;

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_MUL_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier: one partial-product step per cycle for WIDTH cycles,
// then a one-cycle done pulse with the full 2*WIDTH product held stable.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;

  assign busy = (count != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        mcand   <= {{WIDTH{1'b0}}, multiplicand};
        mplier  <= multiplier;
        product <= '0;
        count   <= CW'(WIDTH);
      end else if (busy) begin
        if (mplier[0]) product <= product + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count - 1'b1;
        // Pulse lands in the cycle after the final step, when product is complete.
        done   <= (count == CW'(1));
      end
    end
  end

endmodule

// File: rtl/alu_pipelined.sv
// Execute-stage ALU with valid/ready on both sides, a sequential multiplier and
// registered result/flag/branch-target outputs.
module alu_pipelined
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       operation,
  input  logic [WIDTH-1:0] data_0,
  input  logic [WIDTH-1:0] data_1,
  input  logic [WIDTH-1:0] r_beq,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] solution,
  output logic [WIDTH-1:0] jump_data,
  output logic             jump_valid,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf,
  output state_t           fsm_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never waits on ready, and the producer holds its payload until that edge.
  state_t state, state_next;

  logic               accept;
  logic               alu_load;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH:0]     add_full;
  logic [WIDTH:0]     sub_full;
  logic [WIDTH-1:0]   res_sol;
  logic [WIDTH-1:0]   res_jd;
  logic               res_jv;
  logic               res_carry;
  logic [WIDTH-1:0]   mul_sol;

  assign in_ready  = (state == S_IDLE) && !mul_busy && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (operation == OP_MUL);
  assign alu_load  = accept && (operation != OP_MUL);
  assign fsm_state = state;

  assign add_full = {1'b0, data_0} + {1'b0, data_1};
  assign sub_full = {1'b0, data_0} - {1'b0, data_1};
  assign mul_sol  = product[WIDTH-1:0];

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clock        (clock),
    .reset        (reset),
    .start        (mul_start),
    .multiplicand (data_0),
    .multiplier   (data_1),
    .busy         (mul_busy),
    .done         (mul_done),
    .product      (product)
  );

  always_comb begin
    res_sol   = '0;
    res_jd    = '0;
    res_jv    = 1'b0;
    res_carry = 1'b0;
    case (operation)
      OP_ADD: begin
        res_sol   = add_full[WIDTH-1:0];
        res_carry = add_full[WIDTH];
      end
      OP_SUB: begin
        // The extra top bit of the widened difference is the borrow.
        res_sol   = sub_full[WIDTH-1:0];
        res_carry = sub_full[WIDTH];
      end
      OP_AND: res_sol = data_0 & data_1;
      OP_OR:  res_sol = data_0 | data_1;
      OP_SLT: res_sol = {{(WIDTH-1){1'b0}}, (data_0 < data_1)};
      OP_BEQ: res_sol = {{(WIDTH-1){1'b0}}, (data_0 == data_1)};
      OP_BNZ: begin
        res_sol = data_0;
        res_jd  = (r_beq == '0) ? data_0 : data_1;
        res_jv  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (mul_start) state_next = S_MUL_BUSY;
      S_MUL_BUSY: if (mul_done)  state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      out_valid  <= 1'b0;
      solution   <= '0;
      jump_data  <= '0;
      jump_valid <= 1'b0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      flag_ovf   <= 1'b0;
    end else begin
      state <= state_next;
      if (alu_load) begin
        out_valid  <= 1'b1;
        solution   <= res_sol;
        jump_data  <= res_jd;
        jump_valid <= res_jv;
        flag_zero  <= (res_sol == '0);
        flag_carry <= res_carry;
        flag_ovf   <= 1'b0;
      end else if (mul_done) begin
        // The result register is already free here: MUL was accepted only when it was.
        out_valid  <= 1'b1;
        solution   <= mul_sol;
        jump_data  <= '0;
        jump_valid <= 1'b0;
        flag_zero  <= (mul_sol == '0);
        flag_carry <= 1'b0;
        flag_ovf   <= (product[2*WIDTH-1:WIDTH] != '0);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipelined.sv
// Directed checks on an 8-bit instance plus a scoreboarded random run on a 16-bit instance.
module tb_alu_pipelined;
  import alu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;

  // 8-bit instance
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [2:0] operation;
  logic [7:0] data_0, data_1, r_beq, solution, jump_data;
  logic       jump_valid, flag_zero, flag_carry, flag_ovf;
  state_t     fsm_state;

  // 16-bit instance
  logic        w16_in_valid, w16_in_ready, w16_out_valid, w16_out_ready;
  logic [2:0]  w16_operation;
  logic [15:0] w16_data_0, w16_data_1, w16_r_beq, w16_solution, w16_jump_data;
  logic        w16_jump_valid, w16_flag_zero, w16_flag_carry, w16_flag_ovf;
  state_t      w16_fsm_state;

  alu_pipelined #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .operation(operation), .data_0(data_0), .data_1(data_1), .r_beq(r_beq),
    .out_valid(out_valid), .out_ready(out_ready), .solution(solution),
    .jump_data(jump_data), .jump_valid(jump_valid), .flag_zero(flag_zero),
    .flag_carry(flag_carry), .flag_ovf(flag_ovf), .fsm_state(fsm_state)
  );

  alu_pipelined #(.WIDTH(16)) dut16 (
    .clock(clock), .reset(reset), .in_valid(w16_in_valid), .in_ready(w16_in_ready),
    .operation(w16_operation), .data_0(w16_data_0), .data_1(w16_data_1), .r_beq(w16_r_beq),
    .out_valid(w16_out_valid), .out_ready(w16_out_ready), .solution(w16_solution),
    .jump_data(w16_jump_data), .jump_valid(w16_jump_valid), .flag_zero(w16_flag_zero),
    .flag_carry(w16_flag_carry), .flag_ovf(w16_flag_ovf), .fsm_state(w16_fsm_state)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] r);
    in_valid  = 1'b1;
    operation = op;
    data_0    = a;
    data_1    = b;
    r_beq     = r;
  endtask

  task automatic expect_res(input string tag, input logic [7:0] sol, input logic z,
                            input logic c, input logic o, input logic jv,
                            input logic [7:0] jd);
    check({tag, ".sol"}, {out_valid, solution}, {1'b1, sol});
    check({tag, ".flags"}, {jump_valid, flag_zero, flag_carry, flag_ovf, jump_data},
          {jv, z, c, o, jd});
  endtask

  // Issues one op (in_valid left high so consecutive calls run back to back).
  task automatic op_check(input string tag, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] r, input logic [7:0] sol,
                          input logic z, input logic c, input logic o, input logic jv,
                          input logic [7:0] jd);
    issue(op, a, b, r);
    step();
    expect_res(tag, sol, z, c, o, jv, jd);
  endtask

  task automatic run_mul(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] sol, input logic o);
    issue(OP_MUL, a, b, 8'h00);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check({tag, ".busy"}, {in_ready, out_valid, fsm_state}, {1'b0, 1'b0, S_MUL_BUSY});
      data_0 = 8'($urandom);
      data_1 = 8'($urandom);
      step();
    end
    expect_res(tag, sol, (sol == 8'h00), 1'b0, o, 1'b0, 8'h00);
    check({tag, ".ready_after"}, in_ready, 1'b1);
  endtask

  // ---------------- 16-bit reference model and scoreboard ----------------
  function automatic logic [35:0] model16(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic [15:0] r);
    logic [15:0] s, jd;
    logic        c, o, jv;
    logic [31:0] p;
    s = '0; jd = '0; c = 1'b0; o = 1'b0; jv = 1'b0;
    p = 32'(a) * 32'(b);
    case (op)
      3'd0: {c, s} = 17'(a) + 17'(b);
      3'd1: begin s = a - b; c = (a < b); end
      3'd2: begin s = p[15:0]; o = (p[31:16] != 16'h0); end
      3'd3: s = a & b;
      3'd4: s = a | b;
      3'd5: s = (a < b) ? 16'd1 : 16'd0;
      3'd6: s = (a == b) ? 16'd1 : 16'd0;
      default: begin s = a; jd = (r == 16'h0) ? a : b; jv = 1'b1; end
    endcase
    return {jv, jd, (s == 16'h0), c, o, s};
  endfunction

  logic [35:0] exp_q[$];
  logic        rand_on  = 1'b0;
  int          accepted = 0;

  always @(negedge clock) begin
    if (rand_on) begin
      if (w16_out_valid && w16_out_ready) begin
        check("rand_q_nonempty", (exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0)
          check("rand_result",
                {w16_jump_valid, w16_jump_data, w16_flag_zero, w16_flag_carry, w16_flag_ovf,
                 w16_solution}, exp_q.pop_front());
      end
      if (w16_in_valid && w16_in_ready) begin
        exp_q.push_back(model16(w16_operation, w16_data_0, w16_data_1, w16_r_beq));
        accepted++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    in_valid = 1'b0; operation = 3'b0; data_0 = '0; data_1 = '0; r_beq = '0;
    out_ready = 1'b1;
    w16_in_valid = 1'b0; w16_operation = 3'b0; w16_data_0 = '0; w16_data_1 = '0;
    w16_r_beq = '0; w16_out_ready = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    check("reset_ready", in_ready, 1'b1);
    check("reset_outs", {out_valid, jump_valid, flag_zero, flag_carry, flag_ovf, solution,
                         jump_data}, '0);
    check("reset_state", fsm_state, S_IDLE);
    check("reset_w16", {w16_in_ready, w16_out_valid, w16_solution, w16_fsm_state},
          {1'b1, 1'b0, 16'h0, S_IDLE});

    // single-cycle ops, back to back
    op_check("add",     OP_ADD, 8'd200, 8'd100, 8'h00, 8'd44,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    op_check("sub_0",   OP_SUB, 8'd5,   8'd5,   8'h00, 8'd0,   1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    op_check("sub_brw", OP_SUB, 8'd3,   8'd5,   8'h00, 8'hFE,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    op_check("or",      OP_OR,  8'hF0,  8'h0F,  8'h00, 8'hFF,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    op_check("slt_t",   OP_SLT, 8'd3,   8'd9,   8'h00, 8'd1,   1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    op_check("slt_f",   OP_SLT, 8'd9,   8'd9,   8'h00, 8'd0,   1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    op_check("beq_t",   OP_BEQ, 8'd7,   8'd7,   8'h00, 8'd1,   1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    op_check("beq_f",   OP_BEQ, 8'd7,   8'd8,   8'h00, 8'd0,   1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    op_check("bnz_r0",  OP_BNZ, 8'h20,  8'h40,  8'h00, 8'h20,  1'b0, 1'b0, 1'b0, 1'b1, 8'h20);
    op_check("bnz_r3",  OP_BNZ, 8'h20,  8'h40,  8'h03, 8'h20,  1'b0, 1'b0, 1'b0, 1'b1, 8'h40);
    in_valid = 1'b0;
    step();
    check("drain", out_valid, 1'b0);

    // multiplies
    run_mul("mul_16x17", 8'd16, 8'd17, 8'h10, 1'b1);
    run_mul("mul_15x17", 8'd15, 8'd17, 8'hFF, 1'b0);
    run_mul("mul_16x16", 8'd16, 8'd16, 8'h00, 1'b1);
    step();

    // back-pressure
    out_ready = 1'b0;
    op_check("bp_add", OP_ADD, 8'd3, 8'd4, 8'h00, 8'd7, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    issue(OP_AND, 8'hF0, 8'h3C, 8'h00);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold", {in_ready, out_valid, solution, flag_zero, flag_carry},
            {1'b0, 1'b1, 8'd7, 1'b0, 1'b0});
      data_0 = 8'($urandom);
      step();
      data_0 = 8'hF0;
    end
    out_ready = 1'b1;
    #1;
    check("bp_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    expect_res("bp_and", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step();
    check("bp_drain", out_valid, 1'b0);

    // reset in the middle of a multiply
    issue(OP_MUL, 8'd3, 8'd3, 8'h00);
    step();
    in_valid = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid", {in_ready, out_valid, fsm_state}, {1'b1, 1'b0, S_IDLE});
    for (int i = 0; i < 12; i++) begin
      step();
      check("rst_mid_quiet", out_valid, 1'b0);
    end

    // 16-bit random run against the model
    rand_on = 1'b1;
    for (int cyc = 0; cyc < 40000 && accepted < 1000; cyc++) begin
      w16_in_valid  = 1'($urandom_range(0, 1));
      w16_operation = 3'($urandom_range(0, 7));
      w16_data_0    = 16'($urandom);
      w16_data_1    = ($urandom_range(0, 3) == 0) ? w16_data_0 : 16'($urandom);
      w16_r_beq     = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom);
      w16_out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    w16_in_valid  = 1'b0;
    w16_out_ready = 1'b1;
    repeat (40) step();
    check("rand_count", accepted, 1000);
    check("rand_drain", exp_q.size(), 0);
    rand_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
